// File: rtl/int_isq_pkg.sv
// rtl/int_isq_pkg.sv - shared types, widths and robid age helper for the integer issue buffer
package int_isq_pkg;

    localparam int INSTR_W      = 32;
    localparam int PC_W         = 32;
    localparam int ROB_SIZE_LOG = 5;
    localparam int ROBID_W      = ROB_SIZE_LOG + 1;
    localparam int SQ_SIZE_LOG  = 4;
    localparam int SQID_W       = SQ_SIZE_LOG + 1;
    localparam int PREG_W       = 6;
    localparam int SRC_W        = 64;
    localparam int RESULT_W     = 64;

    typedef struct packed {
        logic [2:0]      cx_type;
        logic [3:0]      alu_type;
        logic [2:0]      muldiv_type;
        logic            is_unsigned;
        logic            is_imm;
        logic            is_word;
        logic            need_to_wb;
        logic            predict_taken;
        logic [PC_W-1:0] predict_target;
    } int_ctrl_t;

    localparam int INT_CTRL_W = $bits(int_ctrl_t);

    typedef struct packed {
        logic               valid;
        logic               rdy1;
        logic               rdy2;
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [ROBID_W-1:0] robid;
        logic [SQID_W-1:0]  sqid;
        logic [PREG_W-1:0]  prs1;
        logic [PREG_W-1:0]  prs2;
        logic [SRC_W-1:0]   src1;
        logic [SRC_W-1:0]   src2;
        logic [PREG_W-1:0]  prd;
        logic [SRC_W-1:0]   imm;
        int_ctrl_t          ctrl;
    } isq_entry_t;

    // True when a is younger than b; the MSB is the ROB wrap bit.
    function automatic logic robid_younger(input logic [ROBID_W-1:0] a,
                                           input logic [ROBID_W-1:0] b);
        return (a[ROBID_W-1] != b[ROBID_W-1]) ^
               (a[ROB_SIZE_LOG-1:0] > b[ROB_SIZE_LOG-1:0]);
    endfunction

endpackage

// File: rtl/int_issue_buffer_age_squash.sv
// rtl/int_issue_buffer_age_squash.sv - per-entry younger-than-flush mask and surviving prefix length
module isq_age_squash
    import int_isq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]              valid,
    input  logic [DEPTH-1:0][ROBID_W-1:0] robid,
    input  logic [PTR_W-1:0]              head_idx,
    input  logic [ROBID_W-1:0]            flush_robid,
    output logic [DEPTH-1:0]              younger,
    output logic [PTR_W:0]                survivors
);

    logic [PTR_W-1:0] idx;
    logic             open;

    always_comb begin
        younger = '0;
        for (int i = 0; i < DEPTH; i++) begin
            younger[i] = valid[i] && robid_younger(robid[i], flush_robid);
        end
    end

    // Walk from head; the first squashed or empty slot ends the surviving run.
    always_comb begin
        survivors = '0;
        open      = 1'b1;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_idx + PTR_W'(i);
            if (open && valid[idx] && !younger[idx]) begin
                survivors = survivors + {{PTR_W{1'b0}}, 1'b1};
            end else begin
                open = 1'b0;
            end
        end
    end

endmodule

// File: rtl/int_issue_buffer.sv
// rtl/int_issue_buffer.sv - in-order integer issue buffer with writeback wakeup and branch squash
module int_issue_buffer
    import int_isq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  disp_valid,
    output logic                  disp_ready,
    input  logic [INSTR_W-1:0]    disp_instr,
    input  logic [PC_W-1:0]       disp_pc,
    input  logic [ROBID_W-1:0]    disp_robid,
    input  logic [SQID_W-1:0]     disp_sqid,
    input  logic [PREG_W-1:0]     disp_prs1,
    input  logic [PREG_W-1:0]     disp_prs2,
    input  logic [SRC_W-1:0]      disp_src1,
    input  logic [SRC_W-1:0]      disp_src2,
    input  logic                  disp_src1_rdy,
    input  logic                  disp_src2_rdy,
    input  logic [PREG_W-1:0]     disp_prd,
    input  logic [SRC_W-1:0]      disp_imm,
    input  logic [INT_CTRL_W-1:0] disp_ctrl,
    output logic                  int_instr_valid,
    input  logic                  int_instr_ready,
    output logic [INSTR_W-1:0]    int_instr,
    output logic [PC_W-1:0]       int_pc,
    output logic [ROBID_W-1:0]    int_robid,
    output logic [SQID_W-1:0]     int_sqid,
    output logic [SRC_W-1:0]      int_src1,
    output logic [SRC_W-1:0]      int_src2,
    output logic [PREG_W-1:0]     int_prd,
    output logic [SRC_W-1:0]      int_imm,
    output logic [INT_CTRL_W-1:0] int_ctrl,
    input  logic                  intwb0_instr_valid,
    input  logic                  intwb0_need_to_wb,
    input  logic [PREG_W-1:0]     intwb0_prd,
    input  logic [RESULT_W-1:0]   intwb0_result,
    input  logic                  flush_valid,
    input  logic [ROBID_W-1:0]    flush_robid
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    isq_entry_t entries [DEPTH];

    logic [PTR_W:0]                head, tail, count, survivors;
    logic [PTR_W-1:0]              head_idx, tail_idx;
    logic                          full, wb, do_disp, do_issue;
    logic                          wake1_in, wake2_in;
    logic [DEPTH-1:0]              valid_vec, younger;
    logic [DEPTH-1:0][ROBID_W-1:0] robid_vec;
    isq_entry_t                    head_e, new_e;

    assign head_idx = head[PTR_W-1:0];
    assign tail_idx = tail[PTR_W-1:0];
    assign count    = tail - head;
    assign full     = (count == FULL_CNT);
    assign wb       = intwb0_instr_valid && intwb0_need_to_wb;
    assign head_e   = entries[head_idx];

    assign disp_ready      = !full && !flush_valid;
    assign int_instr_valid = head_e.valid && head_e.rdy1 && head_e.rdy2 && !flush_valid;
    assign do_disp         = disp_valid && disp_ready;
    assign do_issue        = int_instr_valid && int_instr_ready;

    assign int_instr = head_e.instr;
    assign int_pc    = head_e.pc;
    assign int_robid = head_e.robid;
    assign int_sqid  = head_e.sqid;
    assign int_src1  = head_e.src1;
    assign int_src2  = head_e.src2;
    assign int_prd   = head_e.prd;
    assign int_imm   = head_e.imm;
    assign int_ctrl  = head_e.ctrl;

    always_comb begin
        valid_vec = '0;
        robid_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entries[i].valid;
            robid_vec[i] = entries[i].robid;
        end
    end

    isq_age_squash #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_age_squash (
        .valid       (valid_vec),
        .robid       (robid_vec),
        .head_idx    (head_idx),
        .flush_robid (flush_robid),
        .younger     (younger),
        .survivors   (survivors)
    );

    // An op whose producer writes back in its dispatch cycle is captured on the way in.
    assign wake1_in = wb && !disp_src1_rdy && (disp_prs1 == intwb0_prd);
    assign wake2_in = wb && !disp_src2_rdy && (disp_prs2 == intwb0_prd);

    always_comb begin
        new_e       = '0;
        new_e.valid = 1'b1;
        new_e.rdy1  = disp_src1_rdy || wake1_in;
        new_e.rdy2  = disp_src2_rdy || wake2_in;
        new_e.instr = disp_instr;
        new_e.pc    = disp_pc;
        new_e.robid = disp_robid;
        new_e.sqid  = disp_sqid;
        new_e.prs1  = disp_prs1;
        new_e.prs2  = disp_prs2;
        new_e.src1  = wake1_in ? intwb0_result : disp_src1;
        new_e.src2  = wake2_in ? intwb0_result : disp_src2;
        new_e.prd   = disp_prd;
        new_e.imm   = disp_imm;
        new_e.ctrl  = int_ctrl_t'(disp_ctrl);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].rdy1  <= 1'b0;
                entries[i].rdy2  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb && entries[i].valid) begin
                    if (!entries[i].rdy1 && (entries[i].prs1 == intwb0_prd)) begin
                        entries[i].src1 <= intwb0_result;
                        entries[i].rdy1 <= 1'b1;
                    end
                    if (!entries[i].rdy2 && (entries[i].prs2 == intwb0_prd)) begin
                        entries[i].src2 <= intwb0_result;
                        entries[i].rdy2 <= 1'b1;
                    end
                end
                if (flush_valid && younger[i]) begin
                    entries[i].valid <= 1'b0;
                end
            end
            if (do_issue) begin
                entries[head_idx].valid <= 1'b0;
                head                    <= head + {{PTR_W{1'b0}}, 1'b1};
            end
            if (do_disp) begin
                entries[tail_idx] <= new_e;
                tail              <= tail + {{PTR_W{1'b0}}, 1'b1};
            end
            if (flush_valid) begin
                tail <= head + survivors;
            end
        end
    end

endmodule

// File: doc/int_issue_buffer.md
Name: int_issue_buffer

Overview:
- In-order issue buffer that sits directly upstream of the integer execute block and drives its int_* instruction interface.
- Accepts dispatched integer ops with source values read at dispatch and holds them until both sources are ready.
- Snoops the intwb0 writeback port to wake up and capture pending source values.
- Squashes entries younger than a redirecting branch on flush_valid.

Parameters:
- DEPTH, 8, number of entries; power of two.
- PTR_W, $clog2(DEPTH), pointer width; internal pointers carry one extra wrap bit.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- disp_valid  in  1  dispatch request
- disp_ready  out  1  buffer can accept
- disp_instr / disp_pc  in  `INSTR_RANGE / `PC_RANGE  instruction, pc
- disp_robid  in  `ROB_SIZE_LOG+1  ROB id, MSB is the wrap bit
- disp_sqid  in  `SQ_SIZE_LOG+1  store-queue id
- disp_prs1 / disp_prs2  in  `PREG_RANGE  source pregs
- disp_src1 / disp_src2  in  `SRC_RANGE  values read at dispatch
- disp_src1_rdy / disp_src2_rdy  in  1  value already valid
- disp_prd  in  `PREG_RANGE  destination preg
- disp_imm  in  `SRC_RANGE  immediate
- disp_ctrl  in  INT_CTRL_W  packed control (cx/alu/muldiv type, is_unsigned, is_imm, is_word, need_to_wb, predict_taken, predict_target)
- int_instr_valid  out  1  issue to execute
- int_instr_ready  in  1  execute accepts
- int_instr, int_pc, int_robid, int_sqid, int_src1, int_src2, int_prd, int_imm, int_ctrl  out  same widths  head payload
- intwb0_instr_valid / intwb0_need_to_wb  in  1  writeback snoop
- intwb0_prd  in  `PREG_RANGE  writeback preg
- intwb0_result  in  `RESULT_RANGE  writeback value
- flush_valid  in  1  redirect
- flush_robid  in  `ROB_SIZE_LOG+1  robid of the redirecting branch

Behaviour:
- Reset (clock edge with reset_n=0): head=tail=0, all entry valid and ready bits 0, int_instr_valid=0, disp_ready=1. Payload outputs are don't-care while int_instr_valid=0.
- Storage is a circular FIFO; count = tail − head using the wrap bits. Full when count==DEPTH; empty when count==0.
- disp_ready = !full && !flush_valid. There is no same-cycle pop credit, so a full buffer refuses dispatch even while the head issues.
- Dispatch fires on disp_valid && disp_ready. It writes entry[tail] and increments tail.
- Wakeup condition: wb = intwb0_instr_valid && intwb0_need_to_wb. While wb is true, every valid entry with a non-ready srcN whose prsN==intwb0_prd captures intwb0_result into srcN and sets rdyN at the clock edge.
- Wakeup also applies to the entry being dispatched in the same cycle.
- prs==0 is not special-cased; dispatch supplies rdy=1 for it.
- Issue rule: int_instr_valid = entry[head].valid && rdy1 && rdy2 && !flush_valid.
- A wakeup makes the head issuable on the next cycle at the earliest. There is no combinational writeback-to-issue bypass.
- Issue handshake completes on int_instr_valid && int_instr_ready. The head entry is invalidated and head increments.
- Issue is strictly in order: a non-ready head blocks all younger entries.
- Age compare: e is younger than f iff (e.wrap != f.wrap) XOR (e.idx > f.idx).
- Flush: at the edge with flush_valid=1, every valid entry strictly younger than flush_robid is invalidated.
- Flush tail update: survivors form a contiguous prefix from head, and tail = head + survivors.
- Flush during an issue attempt: no dispatch and no issue occur that cycle. Wakeup still applies to surviving entries.
- Simultaneous dispatch and issue with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointer wrap at DEPTH toggles the wrap bit.

Decomposition:
- Shared package int_isq_pkg holds:
  - int_ctrl_t, the packed control struct, and INT_CTRL_W;
  - isq_entry_t, the payload plus valid/rdy bits;
  - function robid_younger(a,b).
- One sub-module, isq_age_squash: combinational per-entry younger mask plus survivor count. It is reused later by the load/store queues.

Test Plan:
- Reset then dispatch one op with rdy1=rdy2=1, int_instr_ready=1 → int_instr_valid=1 on the following cycle with a matching payload; count returns to 0.
- Dispatch op A with prs1=5, rdy1=0; intwb0 writes prd=5, result=0xDEAD two cycles later → A issues the cycle after the writeback with int_src1=0xDEAD. A writeback to prd=6 does not wake A.
- Dispatch 8 ops with int_instr_ready=0 → disp_ready=0 at count 8. Raising ready drains ops in dispatch order; pointers wrap and order is preserved across wrap.
- Buffer holds robids 3,4,5,6; flush_robid=4 → entries 5 and 6 are dropped, tail=head+2, int_instr_valid=0 during the flush cycle, and robid 3 issues afterwards.
- Wrap-bit age: entries with robid {1,31} (wrap 0) and {0,2} (wrap 1), flush_robid = wrap-0 idx 31 → only the wrap-1 entries are squashed.
- Dispatch of op B coincides with a wakeup writeback for B's prs2 → B is stored with rdy2=1 and the captured value.
